// File: rtl/ref_win_addr_gen.sv
// Reference-window memory controller: preloads the search window into banked RAMs,
// then streams column-rotated read addresses and a bank shift to the PE array.
module ref_win_addr_gen #(
   parameter int NUM_BANKS  = 32,
   parameter int ADDR_W     = 7,
   parameter int GROUP      = 4,
   parameter int PRE_ROWS   = 96,
   parameter int PRIME_ROWS = 4,
   parameter int BLK_ROWS   = 24,
   parameter int NUM_COLS   = 7,
   parameter int SHIFT_STEP = 8,
   parameter int STALL_LO   = 7,
   parameter int STALL_HI   = 19
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          src_valid,
   input  logic                          pe_ready,
   output logic [NUM_BANKS-1:0]          bank_sel,
   output logic                          wr_en,
   output logic [NUM_BANKS*ADDR_W-1:0]   wr_addr_all,
   output logic                          rd_en,
   output logic [NUM_BANKS*ADDR_W-1:0]   rd_addr_all,
   output logic [$clog2(NUM_BANKS)-1:0]  shift_value,
   output logic                          half_sel,
   output logic [$clog2(NUM_COLS+1)-1:0] col_idx,
   output logic                          busy,
   output logic                          done
);

   localparam int NUM_GROUPS = NUM_BANKS / GROUP;
   localparam int COLS_PER_PAGE = NUM_BANKS / SHIFT_STEP;
   localparam int MAX_A = (PRE_ROWS > BLK_ROWS) ? PRE_ROWS : BLK_ROWS;
   localparam int MAX_ROWS = (MAX_A > PRIME_ROWS) ? MAX_A : PRIME_ROWS;
   localparam int GW = $clog2(NUM_GROUPS + 1);
   localparam int RW = $clog2(MAX_ROWS + 1);
   localparam int SW = $clog2(NUM_BANKS);
   localparam int CW = $clog2(NUM_COLS + 1);
   localparam int DW = NUM_BANKS * ADDR_W;

   typedef enum logic [1:0] {IDLE, PRELOAD, PRIME, SEARCH} state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   grp_q, grp_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   col_q, col_d;
   logic            half_q, half_d;
   logic            stall_q, stall_d;
   logic            last_q, last_d;

   logic [NUM_BANKS-1:0] bank_sel_d;
   logic                 wr_en_d, rd_en_d, half_sel_d, busy_d, done_d;
   logic [DW-1:0]        wr_addr_d, rd_addr_d;
   logic [SW-1:0]        shift_d;
   logic [CW-1:0]        col_idx_d;

   int   split, base_hi, base_lo;
   logic in_stall;

   // Rotation split and the two page bases for the current column/half/row.
   always_comb begin
      split   = (int'(col_q) % COLS_PER_PAGE) * SHIFT_STEP;
      base_hi = int'(row_q) + (int'(col_q) / COLS_PER_PAGE + int'(half_q)) * BLK_ROWS;
      base_lo = base_hi + BLK_ROWS;
      in_stall = (int'(row_q) >= STALL_LO) && (int'(row_q) <= STALL_HI);
   end

   always_comb begin
      // NOTE: every always_comb target gets a default first so no path can infer a latch.
      state_d    = state_q;
      grp_d      = grp_q;
      row_d      = row_q;
      col_d      = col_q;
      half_d     = half_q;
      stall_d    = stall_q;
      last_d     = last_q;
      bank_sel_d = '0;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_all;
      rd_en_d    = 1'b0;
      rd_addr_d  = rd_addr_all;
      shift_d    = shift_value;
      half_sel_d = half_sel;
      col_idx_d  = col_idx;
      done_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            // The done cycle already sits in IDLE; a start there must not relaunch.
            if (start && !done) begin
               state_d = PRELOAD;
               grp_d   = '0;
               row_d   = '0;
            end
         end
         PRELOAD: begin
            if (src_valid) begin
               wr_en_d = 1'b1;
               bank_sel_d[int'(grp_q)*GROUP +: GROUP] = '1;
               for (int b = 0; b < NUM_BANKS; b++)
                  wr_addr_d[b*ADDR_W +: ADDR_W] = ADDR_W'(row_q);
               if (row_q == RW'(PRE_ROWS-1)) begin
                  row_d = '0;
                  if (grp_q == GW'(NUM_GROUPS-1)) begin
                     grp_d   = '0;
                     state_d = PRIME;
                  end else begin
                     grp_d = grp_q + GW'(1);
                  end
               end else begin
                  row_d = row_q + RW'(1);
               end
            end
         end
         PRIME: begin
            if (pe_ready) begin
               rd_en_d    = 1'b1;
               shift_d    = '0;
               half_sel_d = 1'b0;
               col_idx_d  = '0;
               for (int b = 0; b < NUM_BANKS; b++)
                  rd_addr_d[b*ADDR_W +: ADDR_W] = ADDR_W'(row_q);
               if (row_q == RW'(PRIME_ROWS-1)) begin
                  row_d   = '0;
                  col_d   = '0;
                  half_d  = 1'b0;
                  stall_d = 1'b0;
                  state_d = SEARCH;
               end else begin
                  row_d = row_q + RW'(1);
               end
            end
         end
         SEARCH: begin
            if (last_q) begin
               done_d  = 1'b1;
               last_d  = 1'b0;
               state_d = IDLE;
            end else if (pe_ready) begin
               rd_en_d    = 1'b1;
               shift_d    = SW'(split);
               half_sel_d = half_q;
               col_idx_d  = col_q;
               for (int b = 0; b < NUM_BANKS; b++)
                  rd_addr_d[b*ADDR_W +: ADDR_W] = (b < split) ? ADDR_W'(base_lo) : ADDR_W'(base_hi);
               if (in_stall && !stall_q) begin
                  stall_d = 1'b1;
               end else begin
                  stall_d = 1'b0;
                  if (row_q == RW'(BLK_ROWS-1)) begin
                     row_d = '0;
                     if (half_q) begin
                        half_d = 1'b0;
                        if (col_q == CW'(NUM_COLS-1)) begin
                           col_d  = '0;
                           last_d = 1'b1;
                        end else begin
                           col_d = col_q + CW'(1);
                        end
                     end else begin
                        half_d = 1'b1;
                     end
                  end else begin
                     row_d = row_q + RW'(1);
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grp_q       <= '0;
         row_q       <= '0;
         col_q       <= '0;
         half_q      <= 1'b0;
         stall_q     <= 1'b0;
         last_q      <= 1'b0;
         bank_sel    <= '0;
         wr_en       <= 1'b0;
         wr_addr_all <= '0;
         rd_en       <= 1'b0;
         rd_addr_all <= '0;
         shift_value <= '0;
         half_sel    <= 1'b0;
         col_idx     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q     <= state_d;
         grp_q       <= grp_d;
         row_q       <= row_d;
         col_q       <= col_d;
         half_q      <= half_d;
         stall_q     <= stall_d;
         last_q      <= last_d;
         bank_sel    <= bank_sel_d;
         wr_en       <= wr_en_d;
         wr_addr_all <= wr_addr_d;
         rd_en       <= rd_en_d;
         rd_addr_all <= rd_addr_d;
         shift_value <= shift_d;
         half_sel    <= half_sel_d;
         col_idx     <= col_idx_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

endmodule

// File: tb/tb_ref_win_addr_gen.sv
// Directed self-checking bench for ref_win_addr_gen: preload order, rotated search
// addresses, reuse stall, flow control, done pulse and asynchronous abort.
module tb_ref_win_addr_gen;

   localparam int NB       = 32;
   localparam int AW       = 7;
   localparam int DW       = NB * AW;
   localparam int TOTAL_WR = 768;
   localparam int TOTAL_RD = 522;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          src_valid = 1'b0;
   logic          pe_ready = 1'b0;
   logic [NB-1:0] bank_sel;
   logic          wr_en;
   logic [DW-1:0] wr_addr_all;
   logic          rd_en;
   logic [DW-1:0] rd_addr_all;
   logic [4:0]    shift_value;
   logic          half_sel;
   logic [2:0]    col_idx;
   logic          busy;
   logic          done;

   ref_win_addr_gen dut (
      .clk(clk), .rst_n(rst_n), .start(start), .src_valid(src_valid), .pe_ready(pe_ready),
      .bank_sel(bank_sel), .wr_en(wr_en), .wr_addr_all(wr_addr_all),
      .rd_en(rd_en), .rd_addr_all(rd_addr_all), .shift_value(shift_value),
      .half_sel(half_sel), .col_idx(col_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] exp_addr  [TOTAL_RD];
   logic [4:0]    exp_shift [TOTAL_RD];
   logic          exp_half  [TOTAL_RD];
   logic [2:0]    exp_col   [TOTAL_RD];
   logic [DW-1:0] obs_addr  [TOTAL_RD];
   logic [4:0]    obs_shift [TOTAL_RD];
   logic [NB-1:0] obs_sel96, obs_sel767;
   logic [DW-1:0] obs_wr96, obs_wr767;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] fill(input int v);
      logic [DW-1:0] f;
      for (int b = 0; b < NB; b++) f[b*AW +: AW] = AW'(v);
      return f;
   endfunction

   // Expected read stream: 4 prime rows, then column/half/row with rows 7..19 doubled.
   task automatic build_expected();
      int i = 0;
      for (int r = 0; r < 4; r++) begin
         exp_addr[i] = fill(r); exp_shift[i] = 0; exp_half[i] = 0; exp_col[i] = 0; i++;
      end
      for (int c = 0; c < 7; c++)
         for (int h = 0; h < 2; h++)
            for (int r = 0; r < 24; r++)
               for (int k = 0; k < ((r >= 7 && r <= 19) ? 2 : 1); k++) begin
                  for (int b = 0; b < NB; b++)
                     exp_addr[i][b*AW +: AW] =
                        AW'((r + (c / 4 + h + ((b < (c % 4) * 8) ? 1 : 0)) * 24) % 128);
                  exp_shift[i] = 5'((c % 4) * 8);
                  exp_half[i]  = h[0];
                  exp_col[i]   = 3'(c);
                  i++;
               end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_en"}, wr_en, 0);
      check({tag, "_bank_sel"}, bank_sel, 0);
      check({tag, "_wr_addr"}, wr_addr_all, 0);
      check({tag, "_rd_en"}, rd_en, 0);
      check({tag, "_rd_addr"}, rd_addr_all, 0);
      check({tag, "_shift"}, shift_value, 0);
      check({tag, "_half"}, half_sel, 0);
      check({tag, "_col"}, col_idx, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   // One start-to-done pass; stop_rd >= 0 returns early after that many reads.
   task automatic do_run(input bit gaps, input bit rnd, input int stop_rd);
      int  wr_n = 0, rd_n = 0, done_n = 0;
      bit  pv = 1'b1;
      bit  finished = 1'b0;
      @(negedge clk);
      start = 1'b1; src_valid = 1'b1; pe_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (!pv && wr_n < TOTAL_WR) check("gap_wr_en", wr_en, 0);
         if (wr_en) begin
            logic [NB-1:0] es = '0;
            es[(wr_n / 96) * 4 +: 4] = 4'hF;
            if (wr_n < TOTAL_WR) begin
               check("wr_bank_sel", bank_sel, es);
               check("wr_addr", wr_addr_all, fill(wr_n % 96));
            end
            if (wr_n == 96)  begin obs_sel96  = bank_sel; obs_wr96  = wr_addr_all; end
            if (wr_n == 767) begin obs_sel767 = bank_sel; obs_wr767 = wr_addr_all; end
            wr_n++;
         end else begin
            if (busy && wr_n < TOTAL_WR) check("idle_bank_sel", bank_sel, 0);
         end
         if (rd_en) begin
            if (rd_n < TOTAL_RD) begin
               check("rd_addr", rd_addr_all, exp_addr[rd_n]);
               check("rd_shift", shift_value, exp_shift[rd_n]);
               check("rd_half", half_sel, exp_half[rd_n]);
               check("rd_col", col_idx, exp_col[rd_n]);
               obs_addr[rd_n]  = rd_addr_all;
               obs_shift[rd_n] = shift_value;
            end
            rd_n++;
         end
         if (stop_rd >= 0 && rd_n == stop_rd) return;
         if (done) begin
            done_n++;
            check("done_busy", busy, 0);
            check("done_rd_en", rd_en, 0);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 4; k++) begin
               check("post_done_busy", busy, 0);
               if (done) done_n++;
               @(negedge clk);
            end
            finished = 1'b1;
         end else begin
            pv        = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            src_valid = pv;
            pe_ready  = rnd ? $urandom_range(0, 1) : 1'b1;
         end
      end
      check("wr_beats", wr_n, TOTAL_WR);
      check("rd_count", rd_n, TOTAL_RD);
      check("done_pulses", done_n, 1);
   endtask

   initial begin
      build_expected();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset");

      // Full-rate run with hand-computed spot checks.
      do_run(1'b0, 1'b0, -1);
      check("beat96_sel", obs_sel96, 32'h0000_00F0);
      check("beat96_addr", obs_wr96, fill(0));
      check("beat767_sel", obs_sel767, 32'hF000_0000);
      check("beat767_addr", obs_wr767, fill(95));
      check("prime3_b0", obs_addr[3][0 +: AW], 3);
      check("c1_r0_b0", obs_addr[78][0 +: AW], 24);
      check("c1_r0_b7", obs_addr[78][7*AW +: AW], 24);
      check("c1_r0_b8", obs_addr[78][8*AW +: AW], 0);
      check("c1_r0_shift", obs_shift[78], 8);
      check("c5_h1_r0_b0", obs_addr[411][0 +: AW], 72);
      check("c5_h1_r0_b31", obs_addr[411][31*AW +: AW], 48);
      check("c5_h1_r5_b3", obs_addr[416][3*AW +: AW], 77);
      check("reuse_r6", obs_addr[10][31*AW +: AW], 6);
      check("reuse_r7a", obs_addr[11][31*AW +: AW], 7);
      check("reuse_r7b", obs_addr[12][31*AW +: AW], 7);
      check("reuse_r8", obs_addr[13][31*AW +: AW], 8);
      check("reuse_r19b", obs_addr[36][31*AW +: AW], 19);
      check("reuse_r20", obs_addr[37][31*AW +: AW], 20);
      check("half1_r0", obs_addr[41][31*AW +: AW], 24);

      // Source gaps plus random PE back-pressure: same order and counts.
      do_run(1'b1, 1'b1, -1);

      // Asynchronous abort mid-SEARCH, then a clean restart from group 0.
      do_run(1'b0, 1'b0, 200);
      #2 rst_n = 1'b0;
      #1 check_all_zero("abort");
      @(negedge clk);
      rst_n = 1'b1;
      src_valid = 1'b0; pe_ready = 1'b0;
      do_run(1'b0, 1'b1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
